// File: rtl/ahb_lite_master_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_pkg : AHB-Lite encodings and types shared by the two-master arbiter.
// Revision : 1.0
// ---------------------------------------------------------------------------
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } mst_t;

  typedef enum logic [1:0] {
    DOWN_NONE = 2'b00,
    DOWN_M0   = 2'b01,
    DOWN_M1   = 2'b10
  } data_own_t;

  // Address-phase control captured alongside the address (HWDATA is not).
  typedef struct packed {
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       lock;
  } ahb_ctrl_t;

  localparam int CTRL_W = $bits(ahb_ctrl_t);

  function automatic logic trans_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_lite_master_arbiter_input_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_arb_input_stage : one-deep address-phase buffer and response mux per master.
// Revision : 1.0
// ---------------------------------------------------------------------------
module ahb_arb_input_stage
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hready,
  input  logic              granted,
  input  logic              data_owner,
  input  logic [ADDR_W-1:0] live_addr,
  input  logic [CTRL_W-1:0] live_ctrl,
  input  logic              bus_hresp,
  output logic              pend,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [CTRL_W-1:0] pend_ctrl,
  output logic              hreadyout,
  output logic              hresp
);

  ahb_ctrl_t live_c;
  logic      capture;
  logic      release_pend;

  assign live_c = ahb_ctrl_t'(live_ctrl);

  // The master believes its NONSEQ was accepted whenever it sees HREADYOUT=1,
  // so a losing master must be buffered here or the transfer is lost.
  assign capture      = hready && hreadyout && !granted && (live_c.trans == HTRANS_NONSEQ);
  assign release_pend = hready && granted && pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_ctrl <= '0;
    end else if (capture) begin
      pend      <= 1'b1;
      pend_addr <= live_addr;
      pend_ctrl <= live_ctrl;
    end else if (release_pend) begin
      pend      <= 1'b0;
    end
  end

  assign hreadyout = pend ? 1'b0 : (data_owner ? hready : 1'b1);
  assign hresp     = data_owner ? bus_hresp : HRESP_OKAY;

endmodule
`default_nettype wire

// File: rtl/ahb_lite_master_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_lite_master_arbiter : shares matrix port SI0 between masters M0 and M1.
// Revision : 1.0
// ---------------------------------------------------------------------------
module ahb_lite_master_arbiter
  import ahb_pkg::*;
#(
  parameter int RR_EN  = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] HADDR_M0,
  input  logic [1:0]        HTRANS_M0,
  input  logic              HWRITE_M0,
  input  logic [2:0]        HSIZE_M0,
  input  logic [2:0]        HBURST_M0,
  input  logic [3:0]        HPROT_M0,
  input  logic              HMASTLOCK_M0,
  input  logic [DATA_W-1:0] HWDATA_M0,
  output logic [DATA_W-1:0] HRDATA_M0,
  output logic              HREADYOUT_M0,
  output logic              HRESP_M0,
  input  logic [ADDR_W-1:0] HADDR_M1,
  input  logic [1:0]        HTRANS_M1,
  input  logic              HWRITE_M1,
  input  logic [2:0]        HSIZE_M1,
  input  logic [2:0]        HBURST_M1,
  input  logic [3:0]        HPROT_M1,
  input  logic              HMASTLOCK_M1,
  input  logic [DATA_W-1:0] HWDATA_M1,
  output logic [DATA_W-1:0] HRDATA_M1,
  output logic              HREADYOUT_M1,
  output logic              HRESP_M1,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  mst_t      addr_own, addr_own_nxt;
  mst_t      last_gnt, last_gnt_nxt;
  data_own_t data_own, data_own_nxt;
  mst_t      gnt, iss;

  ahb_ctrl_t         live_ctrl  [2];
  logic [ADDR_W-1:0] live_addr  [2];
  logic [ADDR_W-1:0] pend_addr  [2];
  logic [CTRL_W-1:0] pend_ctrl  [2];
  logic [1:0]        pend;
  logic [1:0]        req;
  logic [1:0]        gnt_vec;
  logic [1:0]        down_vec;
  logic [1:0]        hreadyout_v;
  logic [1:0]        hresp_v;
  logic              retain;
  logic              iss_req;
  ahb_ctrl_t         iss_ctrl;
  logic [ADDR_W-1:0] iss_addr;

  assign live_addr[0] = HADDR_M0;
  assign live_addr[1] = HADDR_M1;
  assign live_ctrl[0] = '{trans: HTRANS_M0, write: HWRITE_M0, size: HSIZE_M0,
                          burst: HBURST_M0, prot: HPROT_M0, lock: HMASTLOCK_M0};
  assign live_ctrl[1] = '{trans: HTRANS_M1, write: HWRITE_M1, size: HSIZE_M1,
                          burst: HBURST_M1, prot: HPROT_M1, lock: HMASTLOCK_M1};

  assign req[0] = pend[0] | trans_active(live_ctrl[0].trans);
  assign req[1] = pend[1] | trans_active(live_ctrl[1].trans);

  // Bursts (SEQ/BUSY) and locked sequences keep the bus with their owner.
  assign retain = (live_ctrl[addr_own].trans == HTRANS_SEQ)  ||
                  (live_ctrl[addr_own].trans == HTRANS_BUSY) ||
                  live_ctrl[addr_own].lock;

  always_comb begin
    gnt = addr_own;
    if (!retain) begin
      if (req[0] && !req[1]) begin
        gnt = MST_M0;
      end else if (req[1] && !req[0]) begin
        gnt = MST_M1;
      end else if (req[0] && req[1]) begin
        gnt = ((RR_EN != 0) && (last_gnt == MST_M0)) ? MST_M1 : MST_M0;
      end
    end
  end

  // While HREADY is low the address phase on the bus must stay with addr_own.
  assign iss      = HREADY ? gnt : addr_own;
  assign iss_req  = req[iss];
  assign iss_ctrl = pend[iss] ? ahb_ctrl_t'(pend_ctrl[iss]) : live_ctrl[iss];
  assign iss_addr = pend[iss] ? pend_addr[iss] : live_addr[iss];

  assign gnt_vec  = {gnt == MST_M1, gnt == MST_M0};
  assign down_vec = {data_own == DOWN_M1, data_own == DOWN_M0};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_stage
      ahb_arb_input_stage #(
        .ADDR_W (ADDR_W)
      ) u_stage (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .hready     (HREADY),
        .granted    (gnt_vec[i]),
        .data_owner (down_vec[i]),
        .live_addr  (live_addr[i]),
        .live_ctrl  (live_ctrl[i]),
        .bus_hresp  (HRESP),
        .pend       (pend[i]),
        .pend_addr  (pend_addr[i]),
        .pend_ctrl  (pend_ctrl[i]),
        .hreadyout  (hreadyout_v[i]),
        .hresp      (hresp_v[i])
      );
    end
  endgenerate

  always_comb begin
    addr_own_nxt = addr_own;
    last_gnt_nxt = last_gnt;
    data_own_nxt = data_own;
    if (HREADY) begin
      addr_own_nxt = gnt;
      data_own_nxt = !iss_req ? DOWN_NONE : ((gnt == MST_M1) ? DOWN_M1 : DOWN_M0);
      if (iss_req) begin
        last_gnt_nxt = gnt;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_own <= MST_M0;
      last_gnt <= MST_M1;
      data_own <= DOWN_NONE;
    end else begin
      addr_own <= addr_own_nxt;
      last_gnt <= last_gnt_nxt;
      data_own <= data_own_nxt;
    end
  end

  // Reset gates the bus immediately so nothing leaks out while HRESETn is low.
  assign HTRANS    = (iss_req && HRESETn) ? iss_ctrl.trans : HTRANS_IDLE;
  assign HADDR     = HRESETn ? iss_addr : '0;
  assign HMASTLOCK = HRESETn & iss_ctrl.lock;
  assign HWRITE    = iss_ctrl.write;
  assign HSIZE     = iss_ctrl.size;
  assign HBURST    = iss_ctrl.burst;
  assign HPROT     = iss_ctrl.prot;
  assign HWDATA    = (data_own == DOWN_M1) ? HWDATA_M1 : HWDATA_M0;

  assign HRDATA_M0    = HRDATA;
  assign HRDATA_M1    = HRDATA;
  assign HREADYOUT_M0 = hreadyout_v[0];
  assign HREADYOUT_M1 = hreadyout_v[1];
  assign HRESP_M0     = hresp_v[0];
  assign HRESP_M1     = hresp_v[1];

endmodule
`default_nettype wire
